instr_mem_loader: RTL

Program loader that sits in front of the instruction memory of the pipelined RV32I core. It accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words, and writes them sequentially into instruction memory from a fixed base address. It holds the core in a stalled state until the image is complete. It is the writer side of the instruction path: it produces the words the fetch stage and control decoder later consume.

---
 rtl/instr_mem_loader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/instr_mem_loader.sv
// Program loader: assembles little-endian bytes into 32-bit words and writes them
// sequentially into instruction memory. Optional checksum via INSTR_LOADER_CHECKSUM_EN.
module instr_mem_loader #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'hBFC00000,
  parameter int          LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len_words,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done
`ifdef INSTR_LOADER_CHECKSUM_EN
  ,
  output logic                  chk_err
`endif
);

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
`ifdef INSTR_LOADER_CHECKSUM_EN
    S_CHECK = 3'd3,
`endif
    S_DONE  = 3'd4
  } state_t;

  state_t               state, state_nx;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] word_cnt;
  logic [1:0]           byte_idx;
  logic                 start_ok;
  logic                 last_word;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]           sum;
`endif

  // Byte handshake: a byte moves on a rising edge where byte_valid and byte_ready are
  // both high; byte_ready depends only on state, so the sender may hold byte_valid freely.
  assign start_ok  = start && (state == S_IDLE || state == S_DONE);
  assign last_word = (word_cnt == len_q - LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nx = (len_words != '0) ? S_RECV : S_DONE;
      end
      S_RECV: begin
        if (byte_valid && byte_idx == 2'd3) state_nx = S_WRITE;
      end
      S_WRITE: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
        if (last_word) state_nx = S_CHECK;
`else
        if (last_word) state_nx = S_DONE;
`endif
        else state_nx = S_RECV;
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (byte_valid) state_nx = S_DONE;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    imem_we    = 1'b0;
    busy       = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    case (state)
      S_RECV: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      S_WRITE: begin
        imem_we = 1'b1;
        busy    = 1'b1;
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CHECK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
`endif
      S_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= '0;
      word_cnt   <= '0;
      byte_idx   <= '0;
      imem_addr  <= BASE;
      imem_wdata <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      sum        <= '0;
      chk_err    <= 1'b0;
`endif
    end else begin
      if (start_ok && len_words != '0) begin
        len_q     <= len_words;
        word_cnt  <= '0;
        byte_idx  <= '0;
        imem_addr <= BASE;
`ifdef INSTR_LOADER_CHECKSUM_EN
        sum       <= '0;
`endif
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      if (start_ok) chk_err <= 1'b0;
`endif
      if (state == S_RECV && byte_valid) begin
        imem_wdata[{byte_idx, 3'b000} +: 8] <= byte_data;
        byte_idx <= byte_idx + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
        sum      <= sum + byte_data;
`endif
      end
      // Address advances after the write cycle, wrapping silently at the top.
      if (state == S_WRITE) begin
        imem_addr <= imem_addr + ADDR_WIDTH'(4);
        word_cnt  <= word_cnt + LEN_WIDTH'(1);
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      if (state == S_CHECK && byte_valid) chk_err <= (sum != byte_data);
`endif
    end
  end

endmodule
